// File: rtl/mul_latency_unit_pkg.sv
// Shared definitions for the multicycle multiply unit.
//   state_t          : FSM state encoding (IDLE, BUSY, DONE)
//   DEFAULT_LATENCY  : default number of BUSY cycles per multiply
//   DATA_W           : operand / result width
//   cnt_width()      : latency counter width, never below 1 bit
package mul_latency_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_LATENCY = 4;
    localparam int DATA_W          = 32;

    // Width needed to hold LATENCY (the counter is loaded with LATENCY-1,
    // but sizing for LATENCY+1 keeps the formula uniform), minimum 1 bit.
    function automatic int cnt_width(input int lat);
        int w;
        w = $clog2(lat + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/register_with_rst.sv
// Generic enabled register with synchronous active-high reset to zero.
//   clk : clock
//   rst : synchronous reset, active-high, clears q
//   en  : load enable, q <= d when high
//   d   : data in
//   q   : registered data out
module register_with_rst #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mul_latency_unit.sv
// Fixed-latency 32x32 multiplier (low 32 bits, RV32M MUL) that stalls the CPU
// front end while a multiply is outstanding.
//   clk       : clock
//   rst       : synchronous reset, active-high
//   start     : multiply request, held by the CPU while the instruction is in decode
//   a, b      : operands (rs1, rs2), captured when the request is accepted
//   stall     : combinational, request pending and result not yet available
//   busy      : registered, high in BUSY
//   done      : registered, one-cycle pulse in DONE
//   result    : registered product, holds until the next completion
//   state_dbg : current FSM state for observation
//
// Handshake: the CPU raises start and holds it; the unit accepts it in IDLE
// and keeps stall high until the DONE cycle, where stall drops so the PC
// (en = !stall) advances exactly once. start is ignored in BUSY and DONE,
// and a start that drops mid-operation does not abort it.
module mul_latency_unit
    import mul_latency_unit_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output state_t            state_dbg
);

    localparam int CW = cnt_width(LATENCY);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              complete;
    logic [DATA_W-1:0] product;

    // Last BUSY cycle: the product is latched into the result register here,
    // so it becomes visible together with done in the DONE cycle.
    assign complete = (state == BUSY) && (cnt == '0);

    // 32-bit context keeps only the low half of the product.
    assign product = op_a * op_b;

    assign stall     = start && (state != DONE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        cnt   <= CW'(LATENCY - 1);
                        busy  <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (complete) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    register_with_rst #(.W(DATA_W)) u_result (
        .clk (clk),
        .rst (rst),
        .en  (complete),
        .d   (product),
        .q   (result)
    );

endmodule

// File: tb/tb_mul_latency_unit.sv
module tb_mul_latency_unit;
    import mul_latency_unit_pkg::*;

    localparam int L0 = 4;
    localparam int L1 = 1;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 0 (LATENCY=4) ----------------
    logic        rst0, start0;
    logic [31:0] a0, b0;
    logic        stall0, busy0, done0;
    logic [31:0] result0;
    state_t      st0;

    mul_latency_unit #(.LATENCY(L0)) dut0 (
        .clk(clk), .rst(rst0), .start(start0), .a(a0), .b(b0),
        .stall(stall0), .busy(busy0), .done(done0), .result(result0),
        .state_dbg(st0)
    );

    // ---------------- DUT 1 (LATENCY=1) ----------------
    logic        rst1, start1;
    logic [31:0] a1, b1;
    logic        stall1, busy1, done1;
    logic [31:0] result1;
    state_t      st1;

    mul_latency_unit #(.LATENCY(L1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1),
        .stall(stall1), .busy(busy1), .done(done1), .result(result1),
        .state_dbg(st1)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level model: an operation accepted in cycle c occupies
    // cycles c+1..c+L as BUSY and completes in cycle c+L+1.
    int          lat[2];
    bit          act[2];
    int          acc[2];
    logic [31:0] mres[2];
    int          cyc;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic eval_unit(input int u, input logic r, input logic s,
                             input logic [31:0] av, input logic [31:0] bv,
                             input logic st_o, input logic bz_o, input logic dn_o,
                             input logic [31:0] res_o, input state_t sd);
        bit          e_busy, e_done, e_stall;
        logic [31:0] e_res;
        logic [63:0] full;
        state_t      e_state;
        e_busy  = act[u] && (cyc >= acc[u] + 1) && (cyc <= acc[u] + lat[u]);
        e_done  = act[u] && (cyc == acc[u] + lat[u] + 1);
        e_stall = s && !e_done;
        e_state = e_done ? DONE : (e_busy ? BUSY : IDLE);
        e_res   = mres[u];
        if (e_done) begin
            if (u == 0 && exp_q0.size() > 0) e_res = exp_q0.pop_front();
            if (u == 1 && exp_q1.size() > 0) e_res = exp_q1.pop_front();
            mres[u] = e_res;
        end
        check_val($sformatf("u%0d stall c%0d", u, cyc), {31'b0, st_o}, {31'b0, e_stall});
        check_val($sformatf("u%0d busy c%0d", u, cyc), {31'b0, bz_o}, {31'b0, e_busy});
        check_val($sformatf("u%0d done c%0d", u, cyc), {31'b0, dn_o}, {31'b0, e_done});
        check_val($sformatf("u%0d result c%0d", u, cyc), res_o, e_res);
        check_val($sformatf("u%0d state c%0d", u, cyc), {30'b0, sd}, {30'b0, e_state});
        // advance the model across the coming clock edge
        if (r) begin
            act[u]  = 1'b0;
            mres[u] = 32'h0;
            if (u == 0) exp_q0.delete();
            else        exp_q1.delete();
        end else if (e_done) begin
            act[u] = 1'b0;
        end else if (!act[u] && s) begin
            act[u] = 1'b1;
            acc[u] = cyc;
            full   = {32'b0, av} * {32'b0, bv};
            if (u == 0) exp_q0.push_back(full[31:0]);
            else        exp_q1.push_back(full[31:0]);
        end
    endtask

    // One clock cycle: check outputs against inputs set for this cycle,
    // then let the edge happen.
    task automatic tick();
        #1;
        eval_unit(0, rst0, start0, a0, b0, stall0, busy0, done0, result0, st0);
        eval_unit(1, rst1, start1, a1, b1, stall1, busy1, done1, result1, st1);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        lat[0] = L0; lat[1] = L1;
        act[0] = 1'b0; act[1] = 1'b0;
        acc[0] = 0; acc[1] = 0;
        mres[0] = 32'h0; mres[1] = 32'h0;
        cyc = 0;
        rst0 = 1'b1; start0 = 1'b0; a0 = 32'h0; b0 = 32'h0;
        rst1 = 1'b1; start1 = 1'b0; a1 = 32'h0; b1 = 32'h0;
        @(posedge clk);
        #1;
        tick();                       // reset values checked here
        rst0 = 1'b0; rst1 = 1'b0;

        // 7*6, start held from cycle 0 until the DONE cycle
        start0 = 1'b1; a0 = 32'd7; b0 = 32'd6;
        run(6);
        start0 = 1'b0;
        run(2);

        // overflow truncation
        start0 = 1'b1; a0 = 32'hFFFF_FFFF; b0 = 32'd2;
        tick();
        start0 = 1'b0;
        run(6);

        // back-to-back with start held: 3*5 then 4*4
        start0 = 1'b1; a0 = 32'd3; b0 = 32'd5;
        tick();
        a0 = 32'd4; b0 = 32'd4;
        run(12);
        start0 = 1'b0;
        run(2);

        // operand change during BUSY must not matter
        start0 = 1'b1; a0 = 32'd9; b0 = 32'd9;
        tick();
        start0 = 1'b0;
        tick();
        a0 = 32'd1;
        run(6);

        // reset in BUSY cycle 2, then start accepted right after reset
        start0 = 1'b1; a0 = 32'd5; b0 = 32'd5;
        tick();
        start0 = 1'b0;
        tick();
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0; start0 = 1'b1; a0 = 32'd2; b0 = 32'd3;
        tick();
        start0 = 1'b0;
        run(6);

        // LATENCY=1: 10*10, start dropped in cycle 1
        start1 = 1'b1; a1 = 32'd10; b1 = 32'd10;
        tick();
        start1 = 1'b0;
        run(3);
        // LATENCY=1 with start held: back-to-back every 3 cycles
        start1 = 1'b1; a1 = 32'hDEAD_BEEF; b1 = 32'h1234_5678;
        tick();
        a1 = 32'h8000_0001; b1 = 32'hFFFF_FFFF;
        run(6);
        start1 = 1'b0;
        run(2);

        // randomized traffic on both units
        for (int i = 0; i < 400; i++) begin
            start0 = ($urandom_range(0, 3) != 0);
            a0     = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 20));
            b0     = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 20));
            rst0   = ($urandom_range(0, 60) == 0);
            start1 = ($urandom_range(0, 2) != 0);
            a1     = $urandom;
            b1     = $urandom;
            rst1   = ($urandom_range(0, 60) == 0);
            tick();
        end
        rst0 = 1'b0; rst1 = 1'b0; start0 = 1'b0; start1 = 1'b0;
        run(8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
